// File: rtl/local_frame_stack_if.sv
// Request/response port of the local-variable frame store.
// The CPU side (master) issues requests and receives completion pulses; the store is the slave.
interface local_frame_stack_if #(
  parameter int SLOT_AW = 7
);
  logic               op_valid;
  logic               op_ready;
  logic [2:0]         op;
  logic [SLOT_AW-1:0] index;
  logic [SLOT_AW:0]   count;
  logic [63:0]        wdata;
  logic [1:0]         wtype;
  logic               rsp_valid;
  logic [63:0]        rdata;
  logic [1:0]         rtype;

  modport master (
    output op_valid, op, index, count, wdata, wtype,
    input  op_ready, rsp_valid, rdata, rtype
  );

  modport slave (
    input  op_valid, op, index, count, wdata, wtype,
    output op_ready, rsp_valid, rdata, rtype
  );
endinterface

// File: rtl/local_frame_stack.sv
// Stack of wasm call frames over one synchronous slot RAM: GET/SET/TEE/ENTER/LEAVE with type and bounds traps.
// One request at a time: op_ready drops on acceptance until the response cycle ends; a trap halts until reset.
module local_frame_stack #(
  parameter int SLOT_AW  = 7,
  parameter int FRAME_AW = 3,
  parameter bit USE_64B  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  local_frame_stack_if.slave  bus,
  output logic [3:0]          trap,
  output logic [FRAME_AW-1:0] frame_level,
  output logic [SLOT_AW:0]    frame_size
);
  localparam int SLOTS = 1 << SLOT_AW;
  localparam int DEPTH = 1 << FRAME_AW;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_GET   = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_TEE   = 3'd3;
  localparam logic [2:0] OP_ENTER = 3'd4;
  localparam logic [2:0] OP_LEAVE = 3'd5;

  localparam logic [1:0] TAG_I64 = 2'd1;
  localparam logic [1:0] TAG_F64 = 2'd3;

  localparam logic [3:0] TRAP_BOUNDS   = 4'd1;
  localparam logic [3:0] TRAP_TYPE     = 4'd2;
  localparam logic [3:0] TRAP_DEPTH    = 4'd3;
  localparam logic [3:0] TRAP_OVERFLOW = 4'd4;
  localparam logic [3:0] TRAP_UNDER    = 4'd5;
  localparam logic [3:0] TRAP_WIDE     = 4'd6;
  localparam logic [3:0] TRAP_ILLEGAL  = 4'd7;

  localparam logic [FRAME_AW-1:0]  LVL_ONE    = FRAME_AW'(1);
  localparam logic [FRAME_AW-1:0]  LVL_MAX    = FRAME_AW'(DEPTH - 1);
  localparam logic [SLOT_AW:0]     SZ_ONE     = (SLOT_AW+1)'(1);
  localparam logic [SLOT_AW+1:0]   SLOT_LIMIT = (SLOT_AW+2)'(SLOTS);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ, S_WRITE, S_CLEAR, S_RESP, S_HALT
  } state_t;

  typedef struct packed {
    logic [SLOT_AW:0] base;
    logic [SLOT_AW:0] size;
  } frame_t;

  typedef struct packed {
    logic [63:0] val;
    logic [1:0]  tag;
  } slot_t;

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         trap_nxt;
  logic [3:0]         chk_code;

  logic [2:0]         op_q;
  logic [SLOT_AW-1:0] index_q;
  logic [SLOT_AW:0]   count_q;
  logic [63:0]        wdata_q;
  logic [1:0]         wtype_q;

  // Base is one bit wider than an address so a completely full RAM is not mistaken for base 0.
  logic [SLOT_AW:0]   base_q;
  logic [SLOT_AW:0]   clr_cnt;
  logic [SLOT_AW+1:0] enter_end;
  logic               wide_type;
  logic               accept;

  frame_t             stack_q [DEPTH];
  slot_t              mem [SLOTS];
  slot_t              rd_q;
  slot_t              wr_dat;
  logic [SLOT_AW-1:0] rd_addr;
  logic [SLOT_AW-1:0] wr_addr;
  logic               wr_en;

  assign accept    = bus.op_valid & bus.op_ready;
  assign rd_addr   = base_q[SLOT_AW-1:0] + index_q;
  assign wide_type = (wtype_q == TAG_I64) || (wtype_q == TAG_F64);
  assign enter_end = {1'b0, base_q} + {1'b0, frame_size} + {1'b0, count_q};

  // Pre-checks run in CHECK on the captured request, in trap priority order.
  always_comb begin
    chk_code = 4'd0;
    if (op_q > OP_LEAVE) begin
      chk_code = TRAP_ILLEGAL;
    end else if (!USE_64B && wide_type &&
                 (op_q == OP_SET || op_q == OP_TEE || op_q == OP_ENTER)) begin
      chk_code = TRAP_WIDE;
    end else begin
      case (op_q)
        OP_GET, OP_SET, OP_TEE: begin
          if ({1'b0, index_q} >= frame_size) chk_code = TRAP_BOUNDS;
        end
        OP_ENTER: begin
          if (frame_level == LVL_MAX)       chk_code = TRAP_DEPTH;
          else if (enter_end > SLOT_LIMIT)  chk_code = TRAP_OVERFLOW;
        end
        OP_LEAVE: begin
          if (frame_level == '0) chk_code = TRAP_UNDER;
        end
        default: chk_code = 4'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      trap  <= 4'd0;
    end else begin
      state <= state_nxt;
      trap  <= trap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    trap_nxt  = trap;
    case (state)
      S_IDLE: begin
        if (accept && bus.op != OP_NOP) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (chk_code != 4'd0) begin
          state_nxt = S_HALT;
          trap_nxt  = chk_code;
        end else begin
          case (op_q)
            OP_GET, OP_SET, OP_TEE: state_nxt = S_READ;
            OP_ENTER:               state_nxt = (count_q == '0) ? S_RESP : S_CLEAR;
            default:                state_nxt = S_RESP;
          endcase
        end
      end
      S_READ: begin
        // The read address was already presented during CHECK, so rd_q holds the slot here.
        if (op_q == OP_GET) begin
          state_nxt = S_RESP;
        end else if (rd_q.tag != wtype_q) begin
          state_nxt = S_HALT;
          trap_nxt  = TRAP_TYPE;
        end else begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: state_nxt = S_RESP;
      S_CLEAR: begin
        if (clr_cnt == count_q - SZ_ONE) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.op_ready  = (state == S_IDLE) && !reset;
    bus.rsp_valid = (state == S_RESP);
    bus.rdata     = 64'd0;
    bus.rtype     = 2'd0;
    if (state == S_RESP) begin
      if (op_q == OP_GET) begin
        bus.rdata = rd_q.val;
        bus.rtype = rd_q.tag;
      end else if (op_q == OP_TEE) begin
        bus.rdata = wdata_q;
        bus.rtype = wtype_q;
      end
    end

    wr_en   = 1'b0;
    wr_addr = rd_addr;
    wr_dat  = {wdata_q, wtype_q};
    if (state == S_WRITE) begin
      wr_en = !reset;
    end else if (state == S_CLEAR) begin
      wr_en   = !reset;
      wr_addr = base_q[SLOT_AW-1:0] + clr_cnt[SLOT_AW-1:0];
      wr_dat  = {64'd0, wtype_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= OP_NOP;
      index_q     <= '0;
      count_q     <= '0;
      wdata_q     <= 64'd0;
      wtype_q     <= 2'd0;
      base_q      <= '0;
      frame_size  <= '0;
      frame_level <= '0;
      clr_cnt     <= '0;
    end else begin
      if (accept) begin
        op_q    <= bus.op;
        index_q <= bus.index;
        count_q <= bus.count;
        wdata_q <= bus.wdata;
        wtype_q <= bus.wtype;
      end
      if (state == S_CHECK && chk_code == 4'd0) begin
        if (op_q == OP_ENTER) begin
          base_q      <= base_q + frame_size;
          frame_size  <= count_q;
          frame_level <= frame_level + LVL_ONE;
        end else if (op_q == OP_LEAVE) begin
          base_q      <= stack_q[frame_level - LVL_ONE].base;
          frame_size  <= stack_q[frame_level - LVL_ONE].size;
          frame_level <= frame_level - LVL_ONE;
        end
      end
      clr_cnt <= (state == S_CLEAR) ? clr_cnt + SZ_ONE : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == S_CHECK && chk_code == 4'd0 && op_q == OP_ENTER) begin
      stack_q[frame_level] <= {base_q, frame_size};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    rd_q <= mem[rd_addr];
  end
endmodule

// File: doc/local_frame_stack.md
# local_frame_stack

Parametrised local-variable store for the wasm CPU, replacing the fixed locals area behind `get_local`/`set_local`/`tee_local`. It holds a stack of call frames in one synchronous slot RAM. Each slot holds a 64-bit value and a 2-bit type tag, encoded as in cpu.vh. It adds frame enter/leave with zero-fill, per-slot type checking and bounds traps. It sits between the CPU decode/execute stage and the operand stack, and is driven by a valid/ready request port.

## Interface
- `SLOT_AW`, 7: log2 of total slots across all frames (128).
- `FRAME_AW`, 3: log2 of frame-stack depth (max 7 nested frames).
- `USE_64B`, 1: when 0, any `i64`/`f64` type on SET/TEE/ENTER traps.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `op_valid` in 1: request present.
- `op_ready` out 1: block accepts a request this cycle.
- `op` in 3: operation code. 0 NOP, 1 GET, 2 SET, 3 TEE, 4 ENTER, 5 LEAVE; 6–7 are illegal.
- `index` in SLOT_AW: slot index relative to the current frame base.
- `count` in SLOT_AW+1: number of locals for ENTER.
- `wdata` in 64: write value.
- `wtype` in 2: write type for SET/TEE, or fill type for ENTER.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rdata` out 64: GET/TEE value.
- `rtype` out 2: GET/TEE type.
- `trap` out 4: sticky error code, 0 = none.
- `frame_level` out FRAME_AW: number of entered frames.
- `frame_size` out SLOT_AW+1: slot count of the current frame.

## Operation
- State: `base` (current frame's first slot), `frame_size`, `frame_level`.
- Frame stack: a 2^FRAME_AW-entry register array of saved {base, size} pairs.
- A request is accepted on a rising edge where `op_valid & op_ready`.
- Request fields are captured at acceptance and may change afterwards.
- FSM states:
  - IDLE: `op_ready`=1.
  - READ: RAM read in flight.
  - WRITE: SET/TEE commit.
  - CLEAR: ENTER zero-fill.
  - RESP: `rsp_valid` pulse.
  - HALT: trapped.
- NOP: completes in IDLE, no response.
- GET:
  - If `index >= frame_size`, trap 1.
  - Otherwise READ → RESP; `rdata`/`rtype` = slot[base+index].
- SET/TEE:
  - Bounds check as for GET.
  - READ fetches the stored tag.
  - If the tag is not `wtype`, trap 2 and leave the slot unmodified.
  - Otherwise WRITE stores `{wdata, wtype}`, then RESP.
  - TEE additionally drives `rdata=wdata`, `rtype=wtype`; SET drives `rdata`/`rtype` 0.
- ENTER:
  - If `frame_level == 2^FRAME_AW-1`, trap 3.
  - If `base+frame_size+count > 2^SLOT_AW`, trap 4.
  - Otherwise push {base, frame_size}, then set base += frame_size, frame_size = count, level += 1.
  - CLEAR writes {0, `wtype`} to slots base..base+count-1, one per cycle, then RESP.
  - `count`=0 skips CLEAR.
- LEAVE:
  - If `frame_level`=0, trap 5.
  - Otherwise pop {base, frame_size}, level -= 1, then RESP.
  - Popped slots are not cleared.
- Illegal op: trap 7.
- With `USE_64B`=0, a 64-bit `wtype` on SET/TEE/ENTER gives trap 6, checked before the bounds check.
- Trap priority per request: 7, 6, then the op-specific check.
- Trap behaviour:
  - Entering HALT writes the code to `trap` and holds it until reset.
  - `op_ready`=0 and `rsp_valid`=0 in HALT.
  - No RAM write occurs on the trapping request.

## Timing
- Reset values: `op_ready` 0 while `reset` is high, and 1 in the first cycle after it falls. `rsp_valid` 0; `rdata` 0; `rtype` 0; `trap` 0; `frame_level` 0; `frame_size` 0; base 0.
- RAM contents are not reset.
- Reset has priority over every state. Reset mid-CLEAR aborts the fill and returns to IDLE with level 0.
- Latency counts rising edges after the accepting edge E; `rsp_valid` is high for exactly one cycle.
  - GET: `rsp_valid` high after E+2.
  - SET/TEE: `rsp_valid` high after E+3.
  - ENTER with count N: `rsp_valid` high after E+N+1.
  - LEAVE: `rsp_valid` high after E+1.
- `op_ready` is low from E until the edge that ends the RESP cycle. A new request may be accepted in the cycle after RESP.
- Trap: `trap` becomes nonzero after E+1 for pre-checks, or E+2 for the type mismatch. There is no `rsp_valid` for a trapping request.
- Index arithmetic: the slot address is `base+index`, truncated to SLOT_AW bits. The bounds checks guarantee that no wrap occurs.

## Test plan
- ENTER count=3 `wtype`=`i64`, then GET 0,1,2 → each returns `rdata`=0, `rtype`=`i64`. `frame_size`=3, `frame_level`=1; the ENTER response arrives 4 edges after acceptance.
- SET index 1 `wdata`=3 `i64`, then GET 1 → `rdata`=3, `rtype`=`i64`. TEE index 2 `wdata`=7 → `rdata`=7 on the TEE response itself.
- Nested frames: ENTER 2, SET 0=5; ENTER 1, SET 0=9; LEAVE; GET 0 → 5, `frame_level`=1, `frame_size`=2.
- SET index 0 with `wtype`=`f32` into an `i64` slot → `trap`=2, no `rsp_valid`, `op_ready` stays 0. After reset, `trap`=0 and `frame_level`=0.
- GET index 3 in a 3-slot frame → trap 1.
- LEAVE at level 0 → trap 5.
- ENTER count=129 → trap 4.
- An 8th nested ENTER → trap 3.
- op=6 → trap 7.
- ENTER count=100 with `reset` asserted at cycle 50 → next cycle `op_ready`=1, `frame_level`=0, `frame_size`=0, `rsp_valid` never pulsed.
